// File: rtl/address_gen_pkg.sv
// Shared types and default sizing for the frame-buffer write-address generator.
package address_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_FRAME_WORDS = 8192;

endpackage

// File: rtl/sof_edge_det.sv
// Registers the start-of-frame level and produces a one-cycle pulse on its rising edge.
module sof_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic sof,
  output logic sof_rise
);

  logic sof_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sof_q <= 1'b0;
    else         sof_q <= sof;
  end

  // A sof held high yields exactly one pulse.
  assign sof_rise = sof & ~sof_q;

endmodule

// File: rtl/address_gen.sv
// Write-address generator: one strobe and a linear address per accepted stream beat,
// with an optional blackout window of discarded beats and a single-shot frame.
module address_gen
  import address_gen_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int BLK_START   = 1024,
  parameter int BLK_LEN     = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sof,
  input  logic              tvalid,
  output logic              write_enable,
  output logic [ADDR_W-1:0] bram_addr_in
);

  localparam int CNT_W = ADDR_W + 1;

  logic             sof_rise;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] beat_idx, word_idx;
  logic             in_frame, blanked, we_d;
  logic [ADDR_W-1:0] addr_d;

  sof_edge_det u_sof_edge_det (
    .clk      (clk),
    .resetn   (resetn),
    .sof      (sof),
    .sof_rise (sof_rise)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = bram_addr_in;

    // A sof edge makes the coincident cycle beat 0 of a fresh frame.
    beat_idx = sof_rise ? '0 : beat_q;
    word_idx = sof_rise ? '0 : word_q;
    in_frame = sof_rise || (state_q == ACTIVE);
    blanked  = (BLK_LEN > 0) &&
               (int'(beat_idx) >= BLK_START) &&
               (int'(beat_idx) <  BLK_START + BLK_LEN);

    if (sof_rise) begin
      state_d = ACTIVE;
      beat_d  = '0;
      word_d  = '0;
    end

    if (in_frame && tvalid) begin
      beat_d = (beat_idx == '1) ? beat_idx : beat_idx + CNT_W'(1);
      if (!blanked) begin
        we_d   = 1'b1;
        addr_d = word_idx[ADDR_W-1:0];
        word_d = word_idx + CNT_W'(1);
        if (int'(word_idx) == FRAME_WORDS - 1) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      word_q       <= '0;
      write_enable <= 1'b0;
      bram_addr_in <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      word_q       <= word_d;
      write_enable <= we_d;
      bram_addr_in <= addr_d;
    end
  end

endmodule

// File: tb/tb_address_gen.sv
// Self-checking bench: a small-frame instance with blackout and a default-sized instance,
// both driven by the same stream and compared against a beat-level reference model.
module tb_address_gen;

  localparam int S_AW = 4;
  localparam int D_AW = 13;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sof = 1'b0;
  logic tvalid = 1'b0;

  logic            s_we, d_we;
  logic [S_AW-1:0] s_addr;
  logic [D_AW-1:0] d_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  address_gen #(.ADDR_W(S_AW), .FRAME_WORDS(16), .BLK_START(4), .BLK_LEN(2)) dut_small (
    .clk(clk), .resetn(resetn), .sof(sof), .tvalid(tvalid),
    .write_enable(s_we), .bram_addr_in(s_addr)
  );

  address_gen dut_def (
    .clk(clk), .resetn(resetn), .sof(sof), .tvalid(tvalid),
    .write_enable(d_we), .bram_addr_in(d_addr)
  );

  // Reference model: mode 0 = waiting, 1 = frame running, 2 = frame finished.
  typedef struct {
    bit sof_prev;
    int mode;
    int beat;
    int word;
    bit we;
    int addr;
  } mdl_t;

  mdl_t ms = '{default: 0};
  mdl_t md = '{default: 0};

  function automatic mdl_t mdl_step(mdl_t m, bit s, bit t, int fw, int bs, int bl);
    mdl_t n;
    int   b;
    n          = m;
    n.we       = 1'b0;
    n.sof_prev = s;
    if (s && !m.sof_prev) begin
      n.mode = 1;
      n.beat = 0;
      n.word = 0;
    end
    if (n.mode == 1 && t) begin
      b = n.beat;
      n.beat++;
      if (!(bl > 0 && b >= bs && b < bs + bl)) begin
        n.we   = 1'b1;
        n.addr = n.word;
        n.word++;
        if (n.word == fw) n.mode = 2;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms = '{default: 0};
      md = '{default: 0};
    end else begin
      ms = mdl_step(ms, sof, tvalid, 16, 4, 2);
      md = mdl_step(md, sof, tvalid, 8192, 1024, 0);
    end
  end

  wire [1+S_AW+1+D_AW-1:0] act_vec = {s_we, s_addr, d_we, d_addr};

  function automatic logic [1+S_AW+1+D_AW-1:0] exp_vec();
    logic [31:0] sa, da;
    sa = ms.addr;
    da = md.addr;
    return {ms.we, sa[S_AW-1:0], md.we, da[D_AW-1:0]};
  endfunction

  // Applies inputs for one cycle and returns at the following falling edge.
  task automatic drive(input bit s, input bit t);
    sof    = s;
    tvalid = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      n_vec++;
      if (act_vec !== '0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", cyc, act_vec);
      end
    end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL idle_after_reset cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_single_frame();
    int writes = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1);
      if (s_we) writes++;
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL single_frame cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
    n_vec++;
    if (writes != 16 || s_addr !== 4'd15) begin
      n_err++;
      $display("FAIL single_frame_count writes=%0d last=%0d want 16/15", writes, s_addr);
    end
  endtask

  task automatic test_default_frame();
    int writes = 0;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 8200; i++) begin
      drive(1'b1, 1'b1);
      if (d_we) writes++;
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL default_frame cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
    n_vec++;
    if (writes != 8192 || d_addr !== 13'd8191) begin
      n_err++;
      $display("FAIL default_frame_count writes=%0d last=%0d want 8192/8191", writes, d_addr);
    end
  endtask

  task automatic test_tvalid_toggle();
    drive(1'b0, 1'b0);
    for (int i = 0; i < 44; i++) begin
      drive(1'b1, (i % 2) == 0);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL tvalid_toggle cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_restart();
    int guard = 0;
    drive(1'b0, 1'b0);
    while (ms.word < 9 && guard < 40) begin
      drive(1'b1, 1'b1);
      guard++;
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL restart_pre cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
    n_vec++;
    if (guard >= 40) begin
      n_err++;
      $display("FAIL restart_reach_word9 cycles=%0d limit=40", guard);
    end
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    n_vec++;
    if (s_we !== 1'b1 || s_addr !== 4'd0) begin
      n_err++;
      $display("FAIL restart_first_write we=%b addr=%0d want 1/0", s_we, s_addr);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL restart_post cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    drive(1'b0, 1'b0);
    while (ms.word < 7 && guard < 40) begin
      drive(1'b1, 1'b1);
      guard++;
    end
    resetn = 1'b0;
    #1;
    n_vec++;
    if (act_vec !== '0) begin
      n_err++;
      $display("FAIL reset_async cyc=%0d got=%h want=0", cyc, act_vec);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      n_vec++;
      if (act_vec !== '0) begin
        n_err++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h want=0", cyc, act_vec);
      end
    end
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1);
      n_vec++;
      if (act_vec !== '0) begin
        n_err++;
        $display("FAIL reset_needs_sof cyc=%0d got=%h want=0", cyc, act_vec);
      end
    end
    drive(1'b1, 1'b1);
    n_vec++;
    if (s_we !== 1'b1 || s_addr !== 4'd0 || d_we !== 1'b1 || d_addr !== 13'd0) begin
      n_err++;
      $display("FAIL reset_new_frame got=%h want write at address 0", act_vec);
    end
  endtask

  task automatic test_random();
    bit s = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) s = ~s;
      drive(s, $urandom_range(0, 3) != 0);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_default_frame();
    test_tvalid_toggle();
    test_restart();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
